// File: rtl/sim_uart_hub_pkg.sv
// Shared types and constants for the simulation UART hub.
// Start-up sequencer states plus the character width and FIFO fill pattern.
package sim_uart_hub_pkg;

  localparam int CHAR_W = 8;
  localparam logic [CHAR_W-1:0] FILL_CHAR = 8'hff;

  typedef enum logic [1:0] {
    WAIT,
    INIT,
    RUN
  } hub_state_e;

endpackage

// File: rtl/sim_char_fifo.sv
// Synchronous DEPTH x CHAR_W character FIFO; pop data is shown combinationally from the head.
// A push while full is accepted only if a pop happens in the same cycle.
module sim_char_fifo
  import sim_uart_hub_pkg::*;
#(
  parameter int DEPTH = 16
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              push,
  input  logic [CHAR_W-1:0] push_dat,
  input  logic              pop,
  output logic [CHAR_W-1:0] pop_dat,
  output logic              full,
  output logic              empty
);

  localparam int AW = $clog2(DEPTH);

  logic [CHAR_W-1:0] mem_q [DEPTH];
  logic [CHAR_W-1:0] mem_d [DEPTH];
  logic [AW-1:0]     wr_ptr_q, wr_ptr_d;
  logic [AW-1:0]     rd_ptr_q, rd_ptr_d;
  logic [AW:0]       cnt_q, cnt_d;
  logic              wr_en, rd_en;

  assign full    = (cnt_q == (AW+1)'(DEPTH));
  assign empty   = (cnt_q == '0);
  assign pop_dat = mem_q[rd_ptr_q];

  always_comb begin
    rd_en    = pop && !empty;
    wr_en    = push && (!full || rd_en);
    mem_d    = mem_q;
    wr_ptr_d = wr_ptr_q;
    rd_ptr_d = rd_ptr_q;
    cnt_d    = cnt_q;
    if (wr_en) begin
      mem_d[wr_ptr_q] = push_dat;
      wr_ptr_d        = wr_ptr_q + AW'(1);
    end
    if (rd_en) begin
      rd_ptr_d = rd_ptr_q + AW'(1);
    end
    case ({wr_en, rd_en})
      2'b10:   cnt_d = cnt_q + (AW+1)'(1);
      2'b01:   cnt_d = cnt_q - (AW+1)'(1);
      default: cnt_d = cnt_q;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int i = 0; i < DEPTH; i++) begin
        mem_q[i] <= FILL_CHAR;
      end
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      cnt_q    <= '0;
    end else begin
      mem_q    <= mem_d;
      wr_ptr_q <= wr_ptr_d;
      rd_ptr_q <= rd_ptr_d;
      cnt_q    <= cnt_d;
    end
  end

endmodule

// File: rtl/sim_uart_hub.sv
// Captures N_UART console streams into FIFOs, round-robins them onto one registered host port,
// and sequences simulator start-up (delay, one init pulse, then per-cycle step requests).
module sim_uart_hub
  import sim_uart_hub_pkg::*;
#(
  parameter int N_UART     = 4,
  parameter int DEPTH      = 16,
  parameter int INIT_DELAY = 8,
  parameter int CNT_W      = 16,
  localparam int CH_W      = (N_UART > 1) ? $clog2(N_UART) : 1
) (
  input  logic                       clock,
  input  logic                       reset,
  input  logic [N_UART-1:0]          uart_valid,
  input  logic [CHAR_W*N_UART-1:0]   uart_ch,
  output logic                       host_valid,
  input  logic                       host_ready,
  output logic [CH_W-1:0]            host_chan,
  output logic [CHAR_W-1:0]          host_ch,
  output logic [CNT_W*N_UART-1:0]    drop_cnt,
  output logic                       init_req,
  output logic                       step_req,
  input  logic                       step_hold,
  output logic                       ready_o
);

  localparam int DLY_W = (INIT_DELAY > 0) ? $clog2(INIT_DELAY + 1) : 1;

  logic [N_UART-1:0] fifo_full, fifo_empty, fifo_pop;
  logic [CHAR_W-1:0] fifo_dat [N_UART];

  logic              host_valid_q, host_valid_d;
  logic [CH_W-1:0]   host_chan_q, host_chan_d;
  logic [CHAR_W-1:0] host_ch_q, host_ch_d;
  logic [CH_W-1:0]   ptr_q, ptr_d;
  logic [CNT_W-1:0]  drop_q [N_UART];
  logic [CNT_W-1:0]  drop_d [N_UART];
  logic              load_en, grant_vld;
  logic [CH_W-1:0]   grant, cand;

  hub_state_e        state_q, state_d;
  logic [DLY_W-1:0]  dly_q, dly_d;
  logic              init_req_q, init_req_d;
  logic              step_req_q, step_req_d;
  logic              ready_q, ready_d;

  for (genvar gi = 0; gi < N_UART; gi++) begin : g_chan
    sim_char_fifo #(.DEPTH(DEPTH)) u_fifo (
      .clk      (clock),
      .rst_n    (reset),
      .push     (uart_valid[gi]),
      .push_dat (uart_ch[gi*CHAR_W +: CHAR_W]),
      .pop      (fifo_pop[gi]),
      .pop_dat  (fifo_dat[gi]),
      .full     (fifo_full[gi]),
      .empty    (fifo_empty[gi])
    );
    assign drop_cnt[gi*CNT_W +: CNT_W] = drop_q[gi];
  end

  // Output slot reloads whenever it is empty or being consumed this cycle.
  always_comb begin
    load_en      = !host_valid_q || host_ready;
    grant_vld    = 1'b0;
    grant        = '0;
    cand         = '0;
    fifo_pop     = '0;
    host_valid_d = host_valid_q;
    host_chan_d  = host_chan_q;
    host_ch_d    = host_ch_q;
    ptr_d        = ptr_q;
    for (int j = 0; j < N_UART; j++) begin
      cand = CH_W'((int'(ptr_q) + j) % N_UART);
      if (!grant_vld && !fifo_empty[cand]) begin
        grant_vld = 1'b1;
        grant     = cand;
      end
    end
    if (load_en) begin
      host_valid_d = grant_vld;
      if (grant_vld) begin
        fifo_pop[grant] = 1'b1;
        host_chan_d     = grant;
        host_ch_d       = fifo_dat[grant];
        ptr_d           = (grant == CH_W'(N_UART - 1)) ? '0 : grant + CH_W'(1);
      end
    end
  end

  always_comb begin
    for (int i = 0; i < N_UART; i++) begin
      drop_d[i] = drop_q[i];
      if (uart_valid[i] && fifo_full[i] && !fifo_pop[i] && (drop_q[i] != '1)) begin
        drop_d[i] = drop_q[i] + CNT_W'(1);
      end
    end
  end

  always_comb begin
    state_d = state_q;
    dly_d   = dly_q;
    case (state_q)
      WAIT: begin
        if (dly_q == DLY_W'(INIT_DELAY)) begin
          state_d = INIT;
        end else begin
          dly_d = dly_q + DLY_W'(1);
        end
      end
      INIT:    state_d = RUN;
      RUN:     state_d = RUN;
      default: state_d = WAIT;
    endcase
    init_req_d = (state_d == INIT);
    step_req_d = (state_d == RUN) && !step_hold;
    ready_d    = ready_q || (state_q == INIT);
  end

  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      host_valid_q <= 1'b0;
      host_chan_q  <= '0;
      host_ch_q    <= '0;
      ptr_q        <= '0;
      for (int i = 0; i < N_UART; i++) begin
        drop_q[i] <= '0;
      end
      state_q      <= WAIT;
      dly_q        <= '0;
      init_req_q   <= 1'b0;
      step_req_q   <= 1'b0;
      ready_q      <= 1'b0;
    end else begin
      host_valid_q <= host_valid_d;
      host_chan_q  <= host_chan_d;
      host_ch_q    <= host_ch_d;
      ptr_q        <= ptr_d;
      drop_q       <= drop_d;
      state_q      <= state_d;
      dly_q        <= dly_d;
      init_req_q   <= init_req_d;
      step_req_q   <= step_req_d;
      ready_q      <= ready_d;
    end
  end

  assign host_valid = host_valid_q;
  assign host_chan  = host_chan_q;
  assign host_ch    = host_ch_q;
  assign init_req   = init_req_q;
  assign step_req   = step_req_q;
  assign ready_o    = ready_q;

endmodule
